// File: rtl/bp_be_fe_queue_buffer_pkg.sv
// Shared core-interface types for the FE queue: processor configs and the FE queue packet.
// Width helper keeps module ports tied to the selected configuration.
`timescale 1ns/1ps
package bp_be_fe_queue_buffer_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg     = 2'd0,
    e_bp_single_core_cfg = 2'd1
  } bp_params_e;

  typedef enum logic [1:0] {
    e_fe_fetch     = 2'd0,
    e_fe_exception = 2'd1
  } bp_fe_queue_type_e;

  typedef struct packed {
    bp_fe_queue_type_e msg_type;
    logic [38:0]       pc;
    logic [31:0]       instr;
  } bp_be_fe_queue_s;

  function automatic int unsigned bp_fe_queue_width(input bp_params_e cfg);
    int unsigned w;
    case (cfg)
      e_bp_single_core_cfg: w = $bits(bp_be_fe_queue_s);
      default:              w = $bits(bp_be_fe_queue_s);
    endcase
    return w;
  endfunction

endpackage

// File: rtl/bp_be_fe_queue_buffer_mem.sv
// bsg_mem_1r1w: register-file storage, synchronous write, asynchronous read.
// Contents are never reset.
`timescale 1ns/1ps
module bsg_mem_1r1w #(
  parameter int unsigned width_p = 1,
  parameter int unsigned els_p   = 2,
  localparam int unsigned addr_width_lp = $clog2(els_p)
) (
  input  logic                     w_clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_r [els_p];

  always_ff @(posedge w_clk_i) begin
    if (w_v_i) begin
      mem_r[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bp_be_fe_queue_buffer.sv
// FE queue buffer with speculative read, commit and replay pointers.
// Define BP_FE_QUEUE_ROLL_EN for commit/roll support; otherwise each yumi frees its slot.
`timescale 1ns/1ps
module bp_be_fe_queue_buffer
  import bp_be_fe_queue_buffer_pkg::*;
#(
  parameter bp_params_e  bp_params_p = e_bp_default_cfg,
  parameter int unsigned els_p       = 8,
  localparam int unsigned fe_queue_width_lp = bp_fe_queue_width(bp_params_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         clr_i,

  input  logic [fe_queue_width_lp-1:0] fe_queue_i,
  input  logic                         fe_queue_v_i,
  output logic                         fe_queue_ready_o,

  output logic [fe_queue_width_lp-1:0] fe_queue_o,
  output logic                         fe_queue_v_o,
  input  logic                         fe_queue_yumi_i,

  input  logic                         commit_i,
  input  logic                         roll_i,
  output logic                         empty_o
);

  localparam int unsigned addr_width_lp = $clog2(els_p);
  localparam int unsigned ptr_width_lp  = addr_width_lp + 1;
  localparam logic [ptr_width_lp-1:0] ptr_one_lp = ptr_width_lp'(1);

  logic [ptr_width_lp-1:0] wptr_r, wptr_n;
  logic [ptr_width_lp-1:0] rptr_r, rptr_n;
  logic [ptr_width_lp-1:0] cptr;
  logic                    full;
  logic                    enq;
  logic                    yumi;

  // Full when write and free pointers alias the same slot on opposite wraps.
  assign full = (wptr_r[addr_width_lp] != cptr[addr_width_lp])
             && (wptr_r[addr_width_lp-1:0] == cptr[addr_width_lp-1:0]);

  assign fe_queue_ready_o = ~full;
  assign fe_queue_v_o     = (rptr_r != wptr_r);
  assign empty_o          = (cptr == wptr_r);

  assign enq  = reset_n_i & fe_queue_v_i & ~full & ~clr_i;
  assign yumi = fe_queue_yumi_i & fe_queue_v_o;

  always_comb begin
    wptr_n = wptr_r;
    if (enq) begin
      wptr_n = wptr_r + ptr_one_lp;
    end
  end

`ifdef BP_FE_QUEUE_ROLL_EN
  logic [ptr_width_lp-1:0] cptr_r, cptr_n;
  logic                    commit;

  assign commit = commit_i & (cptr_r != rptr_r);

  // Roll lands on the post-commit cptr so a same-cycle commit is not replayed.
  always_comb begin
    cptr_n = cptr_r;
    if (commit) begin
      cptr_n = cptr_r + ptr_one_lp;
    end
    rptr_n = rptr_r;
    if (roll_i) begin
      rptr_n = cptr_n;
    end else if (yumi) begin
      rptr_n = rptr_r + ptr_one_lp;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i || clr_i) begin
      cptr_r <= '0;
    end else begin
      cptr_r <= cptr_n;
    end
  end

  assign cptr = cptr_r;
`else
  logic unused_ctrl;
  assign unused_ctrl = commit_i | roll_i;

  always_comb begin
    rptr_n = rptr_r;
    if (yumi) begin
      rptr_n = rptr_r + ptr_one_lp;
    end
  end

  assign cptr = rptr_r;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_n_i || clr_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      wptr_r <= wptr_n;
      rptr_r <= rptr_n;
    end
  end

  bsg_mem_1r1w #(
    .width_p (fe_queue_width_lp),
    .els_p   (els_p)
  ) fe_queue_mem (
    .w_clk_i  (clk_i),
    .w_v_i    (enq),
    .w_addr_i (wptr_r[addr_width_lp-1:0]),
    .w_data_i (fe_queue_i),
    .r_addr_i (rptr_r[addr_width_lp-1:0]),
    .r_data_o (fe_queue_o)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i && !clr_i) begin
      assert (!(fe_queue_yumi_i && !fe_queue_v_o))
        else $error("fe_queue_yumi_i asserted while fe_queue_v_o is low");
      assert (!(enq && full))
        else $error("enqueue while full");
`ifdef BP_FE_QUEUE_ROLL_EN
      assert (!(commit_i && (cptr_r == rptr_r)))
        else $error("commit_i asserted with no read-but-uncommitted entry");
`endif
    end
  end
`endif

endmodule

// File: tb/tb_bp_be_fe_queue_buffer.sv
// Directed bench for bp_be_fe_queue_buffer with a queue-based reference model.
// Covers both builds via BP_FE_QUEUE_ROLL_EN.
`timescale 1ns/1ps
module tb_bp_be_fe_queue_buffer;
  import bp_be_fe_queue_buffer_pkg::*;

  localparam int unsigned W   = bp_fe_queue_width(e_bp_default_cfg);
  localparam int unsigned ELS = 8;

  logic         clk_i = 1'b0;
  logic         reset_n_i = 1'b0;
  logic         clr_i = 1'b0;
  logic [W-1:0] fe_queue_i = '0;
  logic         fe_queue_v_i = 1'b0;
  logic         fe_queue_ready_o;
  logic [W-1:0] fe_queue_o;
  logic         fe_queue_v_o;
  logic         fe_queue_yumi_i = 1'b0;
  logic         commit_i = 1'b0;
  logic         roll_i = 1'b0;
  logic         empty_o;

  bp_be_fe_queue_buffer #(
    .bp_params_p (e_bp_default_cfg),
    .els_p       (ELS)
  ) dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .clr_i            (clr_i),
    .fe_queue_i       (fe_queue_i),
    .fe_queue_v_i     (fe_queue_v_i),
    .fe_queue_ready_o (fe_queue_ready_o),
    .fe_queue_o       (fe_queue_o),
    .fe_queue_v_o     (fe_queue_v_o),
    .fe_queue_yumi_i  (fe_queue_yumi_i),
    .commit_i         (commit_i),
    .roll_i           (roll_i),
    .empty_o          (empty_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard: entries from commit point to write point; rd_idx marks the next unread one.
  logic [W-1:0] sb[$];
  int unsigned  rd_idx = 0;
  int unsigned  n_checks = 0;
  int unsigned  n_fail = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  task automatic check_state(input string tag);
    check({tag, ":ready"}, W'(fe_queue_ready_o), W'(sb.size() < ELS));
    check({tag, ":v"},     W'(fe_queue_v_o),     W'(rd_idx < sb.size()));
    check({tag, ":empty"}, W'(empty_o),          W'(sb.size() == 0));
    if (rd_idx < sb.size()) begin
      check({tag, ":data"}, fe_queue_o, sb[rd_idx]);
    end
  endtask

  task automatic step(input logic rst_n, input logic clr, input logic v,
                      input logic [W-1:0] d, input logic y, input logic c,
                      input logic r, input string tag);
    bit accept;
    reset_n_i       = rst_n;
    clr_i           = clr;
    fe_queue_v_i    = v;
    fe_queue_i      = d;
    fe_queue_yumi_i = y;
    commit_i        = c;
    roll_i          = r;
    accept = v && (sb.size() < ELS);
    @(posedge clk_i);
    if (!rst_n || clr) begin
      sb.delete();
      rd_idx = 0;
    end else begin
`ifdef BP_FE_QUEUE_ROLL_EN
      if (c) begin
        void'(sb.pop_front());
        rd_idx--;
      end
      if (r) rd_idx = 0;
      else if (y) rd_idx++;
`else
      if (y) void'(sb.pop_front());
`endif
      if (accept) sb.push_back(d);
    end
    #1;
    check_state(tag);
  endtask

  task automatic enq(input logic [W-1:0] d);
    step(1'b1, 1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0, "enq");
  endtask

  task automatic yumi();
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, "yumi");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, "reset");
    step(1'b0, 1'b0, 1'b1, W'(7), 1'b0, 1'b0, 1'b0, "reset2");
    check("rst_ready", W'(fe_queue_ready_o), W'(1));
    check("rst_v",     W'(fe_queue_v_o),     W'(0));
    check("rst_empty", W'(empty_o),          W'(1));

    // Fill to capacity; the ninth valid must be refused.
    for (int i = 1; i <= 8; i++) enq(W'(i));
    check("full_ready", W'(fe_queue_ready_o), W'(0));
    step(1'b1, 1'b0, 1'b1, W'(9), 1'b0, 1'b0, 1'b0, "ninth");
    check("ninth_head",  fe_queue_o, W'(1));
    check("ninth_ready", W'(fe_queue_ready_o), W'(0));

`ifdef BP_FE_QUEUE_ROLL_EN
    for (int i = 0; i < 3; i++) yumi();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, "roll");
    check("roll_head",  fe_queue_o, W'(1));
    check("roll_ready", W'(fe_queue_ready_o), W'(0));
    yumi();
    yumi();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, "commit");
    check("commit1_ready", W'(fe_queue_ready_o), W'(1));
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, "commit");
    enq(W'(9));
    enq(W'('hA));
    // Enqueue alongside a commit while full: ready is registered, so nothing enters.
    yumi();
    step(1'b1, 1'b0, 1'b1, W'('hB), 1'b0, 1'b1, 1'b0, "enq_commit_full");
    for (int i = 4; i <= 10; i++) begin
      check("wrap_order", fe_queue_o, W'(i));
      yumi();
    end
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, "drain_commit");
    check("drain_empty", W'(empty_o), W'(1));
`else
    yumi();
    yumi();
    check("yumi_frees", W'(fe_queue_ready_o), W'(1));
    enq(W'(9));
    enq(W'('hA));
    // First pass enqueues 0xB alongside a yumi while full; it must be refused.
    for (int i = 3; i <= 10; i++) begin
      check("wrap_order", fe_queue_o, W'(i));
      step(1'b1, 1'b0, (i == 3), W'('hB), 1'b1, 1'b0, 1'b0, "wrap_yumi");
    end
    check("drain_empty", W'(empty_o), W'(1));
    check("drain_v",     W'(fe_queue_v_o), W'(0));
`endif

    // Flush with a same-cycle enqueue that must be dropped.
    for (int i = 1; i <= 5; i++) enq(W'('h10 + i));
    step(1'b1, 1'b1, 1'b1, W'('hF), 1'b0, 1'b0, 1'b0, "clr");
    check("clr_v",     W'(fe_queue_v_o), W'(0));
    check("clr_empty", W'(empty_o),      W'(1));
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, "post_clr_idle");
    enq(W'('h20));
    check("post_clr_head", fe_queue_o, W'('h20));

`ifdef BP_FE_QUEUE_ROLL_EN
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "clr2");
    enq(W'('h31));
    enq(W'('h32));
    enq(W'('h33));
    yumi();
    yumi();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, "commit_roll");
    check("commit_roll_head", fe_queue_o, W'('h32));
`else
    yumi();
    enq(W'('h21));
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, "ignored_ctrl");
    check("ignored_ctrl_head", fe_queue_o, W'('h21));
`endif

    // Reset in the middle of traffic with entries held.
    step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "clr3");
    for (int i = 1; i <= 4; i++) enq(W'('h40 + i));
    step(1'b0, 1'b0, 1'b1, W'('h4F), 1'b1, 1'b0, 1'b0, "mid_reset");
    check("mid_reset_ready", W'(fe_queue_ready_o), W'(1));
    check("mid_reset_v",     W'(fe_queue_v_o),     W'(0));
    check("mid_reset_empty", W'(empty_o),          W'(1));

    for (int i = 1; i <= 8; i++) enq(W'('h50 + i));
    yumi();
    enq(W'('h59));
    check("final_head", fe_queue_o, W'('h52));

    reset_n_i       = 1'b1;
    clr_i           = 1'b0;
    fe_queue_v_i    = 1'b0;
    fe_queue_yumi_i = 1'b0;
    commit_i        = 1'b0;
    roll_i          = 1'b0;
    @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
